// File: rtl/program_loader.sv
// program_loader: streams host bytes into program RAM, one write every two cycles,
// and releases the CPU reset only once a whole number of 3-byte records has landed.
module program_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
    localparam logic [ADDR_W:0] REC = 3;
    state_t state;
    logic [ADDR_W-1:0] addr;
    logic last_r;
    logic [ADDR_W:0] next_count;
    logic records_ok;
    logic at_top;
    assign next_count = byte_count + 1'b1;
    assign records_ok = (next_count % REC) == '0;
    assign at_top = addr == '1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            last_r     <= 1'b0;
            in_ready   <= 1'b0;
            ram_data   <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_count <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state      <= RECV;
                    addr       <= '0;
                    byte_count <= '0;
                    in_ready   <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    cpu_rst    <= 1'b1;
                end
                RECV: if (in_valid) begin
                    state    <= WRITE;
                    in_ready <= 1'b0;
                    ram_we   <= 1'b1;
                    ram_data <= in_data;
                    ram_addr <= addr;
                    last_r   <= in_last;
                end
                WRITE: begin
                    ram_we     <= 1'b0;
                    addr       <= addr + 1'b1;
                    byte_count <= next_count;
                    // last byte decides the outcome; overflow only matters mid-stream
                    if (last_r && records_ok) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else if (last_r || at_top) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads with hand-computed expectations for program_loader.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] byte_count;
    int errors = 0;
    int checks = 0;
    logic [5:0] wa[$];
    logic [7:0] wd[$];

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ram_we) begin
        wa.push_back(ram_addr);
        wd.push_back(ram_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        in_last = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready, 1);
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", done | err, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_data"}, ram_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_count"}, byte_count, 0);
        check({tag, "_cpu_rst"}, cpu_rst, 1);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", in_ready, 0);
        check("idle_cpu_rst", cpu_rst, 1);

        // three-byte program, with a start pulse ignored in RECV
        clear_log();
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_ready", in_ready, 1);
        check("t1_count0", byte_count, 0);
        send_byte(8'h01, 1'b0);
        idle_in();
        pulse_start();
        check("busy_start_ignored_count", byte_count, 1);
        check("busy_start_ignored_busy", busy, 1);
        send_byte(8'h05, 1'b0);
        send_byte(8'h03, 1'b1);
        idle_in();
        wait_end();
        check("t1_writes", wa.size(), 3);
        for (int i = 0; i < 3 && i < wa.size(); i++) check("t1_addr", wa[i], i);
        if (wd.size() == 3) begin
            check("t1_d0", wd[0], 8'h01);
            check("t1_d1", wd[1], 8'h05);
            check("t1_d2", wd[2], 8'h03);
        end
        check("t1_done", done, 1);
        check("t1_err", err, 0);
        check("t1_count", byte_count, 3);
        check("t1_cpu_rst", cpu_rst, 0);
        check("t1_busy_end", busy, 0);
        check("t1_hold_addr", ram_addr, 2);
        check("t1_hold_data", ram_data, 8'h03);

        // restart from DONE, then six bytes with idle gaps
        clear_log();
        pulse_start();
        check("restart_done", done, 0);
        check("restart_cpu_rst", cpu_rst, 1);
        check("restart_count", byte_count, 0);
        check("restart_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h10 + 8'(i), i == 5);
            idle_in();
            repeat (3) @(negedge clk);
        end
        wait_end();
        check("t2_writes", wa.size(), 6);
        bad = 0;
        for (int i = 0; i < wa.size(); i++) if (wa[i] != 6'(i) || wd[i] != 8'h10 + 8'(i)) bad++;
        check("t2_order", bad, 0);
        check("t2_done", done, 1);
        check("t2_count", byte_count, 6);

        // four bytes: not a whole number of records
        clear_log();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), i == 3);
        idle_in();
        wait_end();
        check("t3_writes", wa.size(), 4);
        check("t3_err", err, 1);
        check("t3_done", done, 0);
        check("t3_cpu_rst", cpu_rst, 1);
        check("t3_count", byte_count, 4);

        // 64 bytes without last: overflow
        clear_log();
        pulse_start();
        for (int i = 0; i < 64; i++) send_byte(8'(i * 3 + 1), 1'b0);
        idle_in();
        wait_end();
        repeat (5) @(negedge clk);
        check("t4_writes", wa.size(), 64);
        bad = 0;
        for (int i = 0; i < wa.size(); i++) if (wa[i] != 6'(i) || wd[i] != 8'(i * 3 + 1)) bad++;
        check("t4_order", bad, 0);
        check("t4_err", err, 1);
        check("t4_done", done, 0);
        check("t4_count", byte_count, 64);
        check("t4_ready", in_ready, 0);

        // reset during the write of byte 2
        clear_log();
        pulse_start();
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        #1;
        check("t5_we_before", ram_we, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("t5");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_writes", wa.size(), 1);
        clear_log();
        pulse_start();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b1);
        idle_in();
        wait_end();
        check("t5_reload_writes", wa.size(), 3);
        if (wa.size() > 0) check("t5_reload_addr0", wa[0], 0);
        if (wd.size() > 0) check("t5_reload_data0", wd[0], 8'h31);
        check("t5_done", done, 1);
        check("t5_count", byte_count, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
